ifetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the uP16 instruction memory (1k x 18 BRAM, synchronous read, 1-cycle latency).

---
 rtl/up16_pkg.sv | 15 +
 rtl/ifetch_skid_buf.sv | 52 +++++
 rtl/ifetch_ctrl.sv | 109 ++++++++++
 tb/tb_ifetch_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/up16_pkg.sv
// Shared uP16 definitions: fetch FSM encoding, NOP encoding and instruction memory geometry.
package up16_pkg;

  localparam int IMEM_AWIDTH = 10;
  localparam int IMEM_DEPTH  = 1 << IMEM_AWIDTH;

  localparam logic [17:0] NOP_INSTR = 18'h0_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifetch_skid_buf.sv
// Two-entry FIFO absorbing the one-cycle BRAM latency; the head entry is the registered output.
module ifetch_skid_buf #(
  parameter int WIDTH = 35
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] tail_q;

  // A push into an empty (or just-emptied) buffer lands directly in the head register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= 2'd0;
      head_data <= '0;
      tail_q    <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head_data <= push_data;
          else               tail_q    <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head_data <= tail_q;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head_data <= tail_q;
            tail_q    <= push_data;
          end else begin
            head_data <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_valid = (count != 2'd0);

endmodule

// File: rtl/ifetch_ctrl.sv
// uP16 instruction-fetch sequencer: PC, memory address, redirects and skid buffering.
// Optional bound check enabled by defining IFETCH_BOUND_CHECK_EN.
module ifetch_ctrl
  import up16_pkg::*;
#(
  parameter int              ISIZE    = 18,
  parameter int              DSIZE    = 16,
  parameter int              AWIDTH   = IMEM_AWIDTH,
  parameter logic [DSIZE-1:0] RESET_PC = '0
) (
  input  logic             Clk_In,
  input  logic             Rst_In,
  input  logic             Stall_In,
  input  logic             Redirect_In,
  input  logic [DSIZE-1:0] Target_In,
  output logic [DSIZE-1:0] Mem_Add_Out,
  input  logic [ISIZE-1:0] Mem_Data_In,
  output logic [ISIZE-1:0] Instr_Out,
  output logic [DSIZE-1:0] PC_Out,
  output logic             Valid_Out,
  output logic             Fault_Out
);

`ifdef IFETCH_BOUND_CHECK_EN
  localparam bit BOUND_CHECK = 1'b1;
`else
  localparam bit BOUND_CHECK = 1'b0;
`endif

  localparam int BW = 1 + DSIZE + ISIZE;

  fetch_state_t     state;
  logic [DSIZE-1:0] fetch_pc;
  logic [DSIZE-1:0] req_pc;
  logic             req_vld;
  logic             req_fault;
  logic             fault_hold;
  logic             fault_sticky;

  logic [DSIZE-1:0] issue_addr;
  logic             issue;
  logic             pop;
  logic             push;
  logic [2:0]       occ;
  logic             out_of_range;
  logic [1:0]       count;
  logic [BW-1:0]    push_data;
  logic [BW-1:0]    head_data;
  logic             head_fault;

  assign pop        = Valid_Out & ~Stall_In;
  assign occ        = {1'b0, count} + 3'(req_vld) - 3'(pop);
  assign issue_addr = Redirect_In ? Target_In : fetch_pc;
  assign issue      = Redirect_In | (state == BOOT) | ((occ < 3'd2) & ~fault_hold);
  assign Mem_Add_Out = Rst_In ? RESET_PC : issue_addr;

  assign out_of_range = BOUND_CHECK && ((issue_addr >> AWIDTH) != '0);

  // A redirect kills the word still in flight; its replacement is tagged below.
  assign push      = req_vld & ~Redirect_In;
  assign push_data = {req_fault, req_pc, req_fault ? ISIZE'(NOP_INSTR) : Mem_Data_In};

  always_ff @(posedge Clk_In or posedge Rst_In) begin
    if (Rst_In) begin
      state        <= BOOT;
      fetch_pc     <= RESET_PC;
      req_pc       <= '0;
      req_vld      <= 1'b0;
      req_fault    <= 1'b0;
      fault_hold   <= 1'b0;
      fault_sticky <= 1'b0;
    end else begin
      req_vld <= issue;
      if (issue) begin
        fetch_pc   <= issue_addr + DSIZE'(1);
        req_pc     <= issue_addr;
        req_fault  <= out_of_range;
        fault_hold <= out_of_range;
      end

      case (state)
        BOOT:    state <= RUN;
        default: state <= (Redirect_In || issue) ? RUN : FULL;
      endcase

      // Fault stays visible after the NOP is consumed, until the next redirect.
      if (Redirect_In)                  fault_sticky <= 1'b0;
      else if (Valid_Out && head_fault) fault_sticky <= 1'b1;
    end
  end

  ifetch_skid_buf #(
    .WIDTH(BW)
  ) u_skid (
    .clk       (Clk_In),
    .rst       (Rst_In),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (Redirect_In),
    .head_data (head_data),
    .head_valid(Valid_Out),
    .count     (count)
  );

  assign {head_fault, PC_Out, Instr_Out} = head_data;
  assign Fault_Out = (Valid_Out & head_fault) | fault_sticky;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: cycle table plus consumed-word scoreboard; honours IFETCH_BOUND_CHECK_EN.
module tb_ifetch_ctrl;
  import up16_pkg::*;

`ifdef IFETCH_BOUND_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic        Clk_In = 1'b0;
  logic        Rst_In = 1'b1;
  logic        Stall_In = 1'b0;
  logic        Redirect_In = 1'b0;
  logic [15:0] Target_In = '0;
  logic [15:0] Mem_Add_Out;
  logic [17:0] Mem_Data_In = '0;
  logic [17:0] Instr_Out;
  logic [15:0] PC_Out;
  logic        Valid_Out;
  logic        Fault_Out;

  ifetch_ctrl dut (
    .Clk_In     (Clk_In),
    .Rst_In     (Rst_In),
    .Stall_In   (Stall_In),
    .Redirect_In(Redirect_In),
    .Target_In  (Target_In),
    .Mem_Add_Out(Mem_Add_Out),
    .Mem_Data_In(Mem_Data_In),
    .Instr_Out  (Instr_Out),
    .PC_Out     (PC_Out),
    .Valid_Out  (Valid_Out),
    .Fault_Out  (Fault_Out)
  );

  always #5 Clk_In = ~Clk_In;

  // Registered ROM with mem[a] = a over the implemented address bits.
  always_ff @(posedge Clk_In) Mem_Data_In <= 18'(Mem_Add_Out[9:0]);

  typedef struct {
    bit          stall;
    bit          redir;
    logic [15:0] target;
    int          exp_addr;
    bit          exp_valid;
    logic [15:0] exp_pc;
    bit          exp_fault;
  } vec_t;

  vec_t        vecs[22];
  logic [15:0] sb_q[$];
  int          n_compared = 0;
  int          n_mismatched = 0;

  function automatic vec_t mk(bit st, bit rd, logic [15:0] tg, int addr, bit v, logic [15:0] pc, bit f);
    vec_t r;
    r.stall = st; r.redir = rd; r.target = tg; r.exp_addr = addr;
    r.exp_valid = v; r.exp_pc = pc; r.exp_fault = f;
    return r;
  endfunction

  function automatic logic [17:0] rom_word(logic [15:0] pc);
    if (BC && pc >= 16'(IMEM_DEPTH)) return 18'h0;
    return 18'(pc[9:0]);
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_restart(input logic [15:0] t);
    sb_q.delete();
    for (int k = 0; k < 8; k++) sb_q.push_back(t + 16'(k));
  endtask

  task automatic checkOutput(input vec_t v);
    compare("valid", 32'(Valid_Out), 32'(v.exp_valid));
    compare("fault", 32'(Fault_Out), 32'(v.exp_fault));
    if (v.exp_valid) begin
      compare("pc", 32'(PC_Out), 32'(v.exp_pc));
      compare("instr", 32'(Instr_Out), 32'(rom_word(v.exp_pc)));
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [15:0] exp_pc;
    Stall_In    = v.stall;
    Redirect_In = v.redir;
    Target_In   = v.target;
    #2;
    if (v.exp_addr >= 0) compare("mem_add", 32'(Mem_Add_Out), 32'(v.exp_addr));
    if (Valid_Out && !Stall_In) begin
      if (sb_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL sb_empty: got pc %0h, expected no word", PC_Out);
      end else begin
        exp_pc = sb_q.pop_front();
        compare("sb_pc", 32'(PC_Out), 32'(exp_pc));
        compare("sb_instr", 32'(Instr_Out), 32'(rom_word(exp_pc)));
      end
    end
    if (v.redir) sb_restart(v.target);
    @(posedge Clk_In);
    #1;
    checkOutput(v);
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 16'h0000, 16'h000, 0, 16'h0000, 0);
    vecs[1]  = mk(0, 0, 16'h0000, 16'h001, 1, 16'h0000, 0);
    vecs[2]  = mk(0, 0, 16'h0000, 16'h002, 1, 16'h0001, 0);
    vecs[3]  = mk(0, 0, 16'h0000, 16'h003, 1, 16'h0002, 0);
    vecs[4]  = mk(0, 0, 16'h0000, 16'h004, 1, 16'h0003, 0);
    vecs[5]  = mk(1, 0, 16'h0000, 16'h005, 1, 16'h0003, 0);
    vecs[6]  = mk(1, 0, 16'h0000, 16'h005, 1, 16'h0003, 0);
    vecs[7]  = mk(1, 0, 16'h0000, 16'h005, 1, 16'h0003, 0);
    vecs[8]  = mk(1, 0, 16'h0000, 16'h005, 1, 16'h0003, 0);
    vecs[9]  = mk(1, 0, 16'h0000, 16'h005, 1, 16'h0003, 0);
    vecs[10] = mk(0, 0, 16'h0000, 16'h005, 1, 16'h0004, 0);
    vecs[11] = mk(0, 0, 16'h0000, 16'h006, 1, 16'h0005, 0);
    vecs[12] = mk(0, 0, 16'h0000, 16'h007, 1, 16'h0006, 0);
    vecs[13] = mk(1, 0, 16'h0000, 16'h008, 1, 16'h0006, 0);
    vecs[14] = mk(1, 0, 16'h0000, 16'h008, 1, 16'h0006, 0);
    vecs[15] = mk(0, 1, 16'h0010, 16'h010, 0, 16'h0000, 0);
    vecs[16] = mk(0, 0, 16'h0000, 16'h011, 1, 16'h0010, 0);
    vecs[17] = mk(0, 0, 16'h0000, 16'h012, 1, 16'h0011, 0);
    vecs[18] = mk(1, 1, 16'h0020, 16'h020, 0, 16'h0000, 0);
    vecs[19] = mk(0, 0, 16'h0000, 16'h021, 1, 16'h0020, 0);
    vecs[20] = mk(0, 0, 16'h0000, 16'h022, 1, 16'h0021, 0);
    vecs[21] = mk(0, 0, 16'h0000, 16'h023, 1, 16'h0022, 0);

    // Reset state, with a redirect pending that must not reach the memory address.
    Rst_In = 1'b1; Redirect_In = 1'b1; Target_In = 16'h0055;
    repeat (2) @(posedge Clk_In);
    #1;
    compare("rst_valid", 32'(Valid_Out), 32'd0);
    compare("rst_pc", 32'(PC_Out), 32'd0);
    compare("rst_instr", 32'(Instr_Out), 32'd0);
    compare("rst_fault", 32'(Fault_Out), 32'd0);
    compare("rst_mem_add", 32'(Mem_Add_Out), 32'd0);
    Redirect_In = 1'b0; Target_In = '0; Rst_In = 1'b0;
    sb_restart(16'h0000);

    for (int i = 0; i < 22; i++) applyStimulus(vecs[i]);

    // Asynchronous reset between edges while words are flowing.
    #2 Rst_In = 1'b1;
    #1;
    compare("midrst_valid", 32'(Valid_Out), 32'd0);
    compare("midrst_pc", 32'(PC_Out), 32'd0);
    compare("midrst_instr", 32'(Instr_Out), 32'd0);
    compare("midrst_mem_add", 32'(Mem_Add_Out), 32'd0);
    repeat (2) @(posedge Clk_In);
    #1;
    Rst_In = 1'b0;
    sb_restart(16'h0000);
    applyStimulus(mk(0, 0, 16'h0000, 16'h000, 0, 16'h0000, 0));
    applyStimulus(mk(0, 0, 16'h0000, 16'h001, 1, 16'h0000, 0));
    applyStimulus(mk(0, 0, 16'h0000, 16'h002, 1, 16'h0001, 0));
    applyStimulus(mk(0, 0, 16'h0000, 16'h003, 1, 16'h0002, 0));

    // Crossing the top of implemented memory.
    applyStimulus(mk(0, 1, 16'h03FE, 16'h3FE, 0, 16'h0000, 0));
    applyStimulus(mk(0, 0, 16'h0000, 16'h3FF, 1, 16'h03FE, 0));
    applyStimulus(mk(0, 0, 16'h0000, 16'h400, 1, 16'h03FF, 0));
    applyStimulus(mk(0, 0, 16'h0000, 16'h401, 1, 16'h0400, BC));
    applyStimulus(mk(0, 0, 16'h0000, BC ? 16'h401 : 16'h402, !BC, 16'h0401, BC));
    applyStimulus(mk(0, 0, 16'h0000, BC ? 16'h401 : 16'h403, !BC, 16'h0402, BC));
    applyStimulus(mk(0, 1, 16'h0030, 16'h030, 0, 16'h0000, 0));
    applyStimulus(mk(0, 0, 16'h0000, 16'h031, 1, 16'h0030, 0));
    applyStimulus(mk(0, 0, 16'h0000, 16'h032, 1, 16'h0031, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
